// File: rtl/fir_reload_ctrl.sv
// Run-time coefficient reload sequencer for the FIR compiler core. It reads one bank
// from a registered coefficient ROM, streams it as a single reload packet, then sends the config beat.
module fir_reload_ctrl #(
    parameter int NUM_TAPS = 32,
    parameter int TAP_W    = 5,
    parameter int BANK_W   = 2,
    parameter int COEF_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    reload_req,
    input  logic [BANK_W-1:0]       bank_sel,
    output logic [BANK_W+TAP_W-1:0] coef_addr,
    input  logic [COEF_W-1:0]       coef_data,
    output logic                    m_axis_reload_tvalid,
    input  logic                    m_axis_reload_tready,
    output logic [COEF_W-1:0]       m_axis_reload_tdata,
    output logic                    m_axis_reload_tlast,
    output logic                    m_axis_config_tvalid,
    input  logic                    m_axis_config_tready,
    output logic [7:0]              m_axis_config_tdata,
    output logic                    busy,
    output logic                    done,
    output logic                    req_drop
);

    localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(NUM_TAPS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_LD,
        S_TX,
        S_CFG,
        S_DONE
    } state_t;

    state_t                    state_q, state_d;
    logic [BANK_W-1:0]         bank_q, bank_d;
    logic [TAP_W-1:0]          k_q, k_d, k_next;
    logic [BANK_W+TAP_W-1:0]   addr_q, addr_d;
    logic [COEF_W-1:0]         tdata_q, tdata_d;
    logic                      tvalid_q, tvalid_d;
    logic                      tlast_q, tlast_d;
    logic                      cfg_valid_q, cfg_valid_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      drop_q, drop_d;

    assign k_next = k_q + TAP_W'(1);

    // NOTE: every signal written here gets its default first, so no path can leave one
    // unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        bank_d      = bank_q;
        k_d         = k_q;
        addr_d      = addr_q;
        tdata_d     = tdata_q;
        tvalid_d    = tvalid_q;
        tlast_d     = tlast_q;
        cfg_valid_d = cfg_valid_q;
        done_d      = 1'b0;
        drop_d      = reload_req && (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (reload_req) begin
                    bank_d  = bank_sel;
                    k_d     = '0;
                    addr_d  = {bank_sel, {TAP_W{1'b0}}};
                    state_d = S_RD;
                end
            end
            // The ROM registers the address here; its data is presented during S_LD.
            S_RD: state_d = S_LD;
            S_LD: begin
                tdata_d  = coef_data;
                tvalid_d = 1'b1;
                tlast_d  = (k_q == LAST_TAP);
                state_d  = S_TX;
            end
            S_TX: begin
                if (m_axis_reload_tready) begin
                    tvalid_d = 1'b0;
                    tlast_d  = 1'b0;
                    if (tlast_q) begin
                        state_d = S_CFG;
                    end else begin
                        k_d     = k_next;
                        addr_d  = {bank_q, k_next};
                        state_d = S_RD;
                    end
                end
            end
            // The first CFG cycle raises valid; the handshake is only taken once valid is up.
            S_CFG: begin
                if (!cfg_valid_q) begin
                    cfg_valid_d = 1'b1;
                end else if (m_axis_config_tready) begin
                    cfg_valid_d = 1'b0;
                    done_d      = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values computed above, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            bank_q      <= '0;
            k_q         <= '0;
            addr_q      <= '0;
            tdata_q     <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            cfg_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bank_q      <= bank_d;
            k_q         <= k_d;
            addr_q      <= addr_d;
            tdata_q     <= tdata_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            cfg_valid_q <= cfg_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            drop_q      <= drop_d;
        end
    end

    assign coef_addr            = addr_q;
    assign m_axis_reload_tvalid = tvalid_q;
    assign m_axis_reload_tdata  = tdata_q;
    assign m_axis_reload_tlast  = tlast_q;
    assign m_axis_config_tvalid = cfg_valid_q;
    assign m_axis_config_tdata  = 8'h00;
    assign busy                 = busy_q;
    assign done                 = done_q;
    assign req_drop             = drop_q;

endmodule

// File: tb/tb_fir_reload_ctrl.sv
// Directed bench for fir_reload_ctrl: a registered ROM model, a negedge monitor logging
// channel events, and per-scenario checks against hand-derived values.
module tb_fir_reload_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        reload_req = 1'b0;
    logic [1:0]  bank_sel = 2'd0;
    logic [6:0]  coef_addr;
    logic [15:0] coef_data = 16'h0;
    logic        rl_tvalid, rl_ready, rl_tlast;
    logic [15:0] rl_tdata;
    logic        cfg_tvalid, cfg_ready = 1'b1;
    logic [7:0]  cfg_tdata;
    logic        busy, done, req_drop;
    logic        rl_rand = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int t0      = 0;

    fir_reload_ctrl dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .reload_req           (reload_req),
        .bank_sel             (bank_sel),
        .coef_addr            (coef_addr),
        .coef_data            (coef_data),
        .m_axis_reload_tvalid (rl_tvalid),
        .m_axis_reload_tready (rl_ready),
        .m_axis_reload_tdata  (rl_tdata),
        .m_axis_reload_tlast  (rl_tlast),
        .m_axis_config_tvalid (cfg_tvalid),
        .m_axis_config_tready (cfg_ready),
        .m_axis_config_tdata  (cfg_tdata),
        .busy                 (busy),
        .done                 (done),
        .req_drop             (req_drop)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] rom_val(input int a);
        return 16'((a * 40503 + 12345) & 32'hFFFF);
    endfunction

    logic [15:0] rom [128];
    initial for (int a = 0; a < 128; a++) rom[a] = rom_val(a);
    always @(posedge clk) coef_data <= rom[coef_addr];

    // Reload ready: constant 1, or a pseudo-random mostly-low pattern.
    always @(posedge clk) begin
        #1;
        rl_ready = rl_rand ? ($urandom_range(0, 2) == 0) : 1'b1;
    end
    initial rl_ready = 1'b1;

    // Event log, sampled mid-cycle; a handshake seen here completes on the next edge.
    int          beat_data[$], beat_addr[$], beat_last[$], beat_cyc[$];
    int          tv_rise[$], cfg_rise[$], cfg_hs[$], cfg_hs_data[$];
    int          done_cyc[$], drop_cyc[$], busy_rise[$], busy_fall[$];
    int          stall_err = 0, overlap_err = 0;
    logic        prev_tv = 0, prev_cfg = 0, prev_busy = 0, prev_stall = 0, prev_last = 0;
    logic [15:0] prev_data = 0;

    always @(negedge clk) begin
        if (prev_stall && !(rl_tvalid && rl_tdata == prev_data && rl_tlast == prev_last))
            stall_err++;
        if (rl_tvalid && cfg_tvalid) overlap_err++;
        if (rl_tvalid && !prev_tv) tv_rise.push_back(cyc);
        if (rl_tvalid && rl_ready) begin
            beat_data.push_back(int'(rl_tdata));
            beat_addr.push_back(int'(coef_addr));
            beat_last.push_back(int'(rl_tlast));
            beat_cyc.push_back(cyc);
        end
        if (cfg_tvalid && !prev_cfg) cfg_rise.push_back(cyc);
        if (cfg_tvalid && cfg_ready) begin
            cfg_hs.push_back(cyc);
            cfg_hs_data.push_back(int'(cfg_tdata));
        end
        if (done) done_cyc.push_back(cyc);
        if (req_drop) drop_cyc.push_back(cyc);
        if (busy && !prev_busy) busy_rise.push_back(cyc);
        if (!busy && prev_busy) busy_fall.push_back(cyc);
        prev_stall = rl_tvalid && !rl_ready;
        prev_data  = rl_tdata;
        prev_last  = rl_tlast;
        prev_tv    = rl_tvalid;
        prev_cfg   = cfg_tvalid;
        prev_busy  = busy;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_request(input logic [1:0] b);
        @(posedge clk); #1;
        bank_sel   = b;
        reload_req = 1'b1;
        @(posedge clk); #1;
        reload_req = 1'b0;
        bank_sel   = ~b;
        t0         = cyc;
    endtask

    task automatic wait_done(input string tag);
        logic hit = 1'b0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            @(posedge clk); #1;
            hit = done;
        end
        check(tag, {31'd0, hit}, 32'd1);
    endtask

    task automatic check_packet(input string tag, input int base, input int bank);
        int last_cnt = 0;
        for (int i = 0; i < 32; i++) begin
            check({tag, "_data"}, 32'(beat_data[base+i]), 32'(rom_val(bank*32 + i)));
            check({tag, "_addr"}, 32'(beat_addr[base+i]), 32'(bank*32 + i));
            last_cnt += beat_last[base+i];
        end
        check({tag, "_tlast_beat31"}, 32'(beat_last[base+31]), 32'd1);
        check({tag, "_tlast_count"}, 32'(last_cnt), 32'd1);
    endtask

    int b0, c0, d0, r0, h0, f0, tr0, s0;
    task automatic snap();
        b0 = beat_data.size(); c0 = cfg_rise.size(); d0 = done_cyc.size();
        r0 = drop_cyc.size();  h0 = cfg_hs.size();   f0 = busy_fall.size();
        tr0 = tv_rise.size();  s0 = busy_rise.size();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_tvalid", {31'd0, rl_tvalid}, 32'd0);
        check("rst_addr", 32'(coef_addr), 32'd0);
        check("rst_cfg_tvalid", {31'd0, cfg_tvalid}, 32'd0);
        check("rst_busy_done_drop", {29'd0, busy, done, req_drop}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Bank 2, readies high: full latency profile.
        snap();
        do_request(2'd2);
        wait_done("t1_done_timeout");
        repeat (3) @(posedge clk);
        check("t1_beats", 32'(beat_data.size() - b0), 32'd32);
        if (beat_data.size() - b0 >= 32) begin
            check_packet("t1", b0, 2);
            check("t1_last_hs_cycle", 32'(beat_cyc[b0+31] - t0 + 1), 32'd96);
        end
        check("t1_busy_rise", 32'(busy_rise[s0] - t0), 32'd0);
        check("t1_first_tvalid", 32'(tv_rise[tr0] - t0), 32'd2);
        check("t1_cfg_tvalid", 32'(cfg_rise[c0] - t0), 32'd97);
        check("t1_cfg_beats", 32'(cfg_hs.size() - h0), 32'd1);
        check("t1_cfg_tdata", 32'(cfg_hs_data[h0]), 32'd0);
        check("t1_done_cycle", 32'(done_cyc[d0] - t0), 32'd98);
        check("t1_done_pulses", 32'(done_cyc.size() - d0), 32'd1);
        check("t1_busy_fall", 32'(busy_fall[f0] - t0), 32'd99);

        // Same request under random reload backpressure.
        snap();
        rl_rand = 1'b1;
        do_request(2'd2);
        wait_done("t2_done_timeout");
        rl_rand = 1'b0;
        repeat (3) @(posedge clk);
        check("t2_beats", 32'(beat_data.size() - b0), 32'd32);
        if (beat_data.size() - b0 >= 32) check_packet("t2", b0, 2);
        check("t2_stall_stable", 32'(stall_err), 32'd0);
        check("t2_cfg_beats", 32'(cfg_hs.size() - h0), 32'd1);
        check("t2_done_after_cfg", 32'(done_cyc[d0] - cfg_hs[h0]), 32'd1);

        // Config ready held low for 10 cycles.
        snap();
        cfg_ready = 1'b0;
        do_request(2'd0);
        begin
            logic seen = 1'b0;
            for (int i = 0; i < 300 && !seen; i++) begin
                @(posedge clk); #1;
                seen = cfg_tvalid;
            end
            check("t3_cfg_seen", {31'd0, seen}, 32'd1);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t3_cfg_held", {30'd0, cfg_tvalid, done}, 32'd2);
        end
        @(posedge clk); #1;
        cfg_ready = 1'b1;
        wait_done("t3_done_timeout");
        repeat (3) @(posedge clk);
        check("t3_cfg_beats", 32'(cfg_hs.size() - h0), 32'd1);
        check("t3_done_after_cfg", 32'(done_cyc[d0] - cfg_hs[h0]), 32'd1);
        check("t3_beats", 32'(beat_data.size() - b0), 32'd32);

        // Requests during a load and in the DONE cycle are dropped.
        snap();
        do_request(2'd0);
        while (cyc - t0 < 39) begin
            @(posedge clk); #1;
        end
        bank_sel = 2'd1; reload_req = 1'b1;
        @(posedge clk); #1;
        reload_req = 1'b0;
        begin
            logic hit = 1'b0;
            for (int i = 0; i < 300 && !hit; i++) begin
                @(posedge clk); #1;
                hit = done;
            end
            check("t4_done_seen", {31'd0, hit}, 32'd1);
        end
        bank_sel = 2'd1; reload_req = 1'b1;
        @(posedge clk); #1;
        reload_req = 1'b0;
        repeat (120) @(posedge clk);
        #1;
        check("t4_req_drop", 32'(drop_cyc.size() - r0), 32'd2);
        check("t4_beats", 32'(beat_data.size() - b0), 32'd32);
        if (beat_data.size() - b0 >= 32) check_packet("t4", b0, 0);
        check("t4_done_pulses", 32'(done_cyc.size() - d0), 32'd1);
        check("t4_idle", {31'd0, busy}, 32'd0);

        // Reset in the middle of a packet.
        snap();
        do_request(2'd1);
        begin
            logic hit = 1'b0;
            for (int i = 0; i < 300 && !hit; i++) begin
                @(posedge clk); #1;
                hit = (beat_data.size() - b0 >= 10);
            end
            check("t5_beat10_seen", {31'd0, hit}, 32'd1);
        end
        rst_n = 1'b0;
        #1;
        check("t5_rst_tvalid_tlast", {30'd0, rl_tvalid, rl_tlast}, 32'd0);
        check("t5_rst_tdata", 32'(rl_tdata), 32'd0);
        check("t5_rst_addr", 32'(coef_addr), 32'd0);
        check("t5_rst_flags", {28'd0, cfg_tvalid, busy, done, req_drop}, 32'd0);
        check("t5_no_cfg", 32'(cfg_hs.size() - h0), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        snap();
        do_request(2'd3);
        wait_done("t5_done_timeout");
        repeat (3) @(posedge clk);
        check("t5_beats", 32'(beat_data.size() - b0), 32'd32);
        if (beat_data.size() - b0 >= 32) check_packet("t5", b0, 3);
        check("t5_cfg_beats", 32'(cfg_hs.size() - h0), 32'd1);

        // Back-to-back: the second request lands in the cycle after done.
        snap();
        do_request(2'd1);
        wait_done("t6_done1_timeout");
        @(posedge clk); #1;
        bank_sel = 2'd2; reload_req = 1'b1;
        @(posedge clk); #1;
        reload_req = 1'b0;
        wait_done("t6_done2_timeout");
        repeat (3) @(posedge clk);
        check("t6_beats", 32'(beat_data.size() - b0), 32'd64);
        if (beat_data.size() - b0 >= 64) begin
            check_packet("t6a", b0, 1);
            check_packet("t6b", b0 + 32, 2);
        end
        check("t6_cfg_beats", 32'(cfg_hs.size() - h0), 32'd2);
        check("t6_done_pulses", 32'(done_cyc.size() - d0), 32'd2);
        check("t6_no_drop", 32'(drop_cyc.size() - r0), 32'd0);
        check("all_overlap", 32'(overlap_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
